// File: rtl/draw_ball_if.sv
// Shared VGA screen geometry and the pixel-stream interface passed between
// the draw stages (paddle, ball, score).

package vga_pkg;
    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
endpackage

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ball.sv
// Ball draw stage: overlays a square ball on the incoming VGA stream and
// moves it once per frame, bouncing off the walls and the left paddle.
// Optional build macro BALL_SPEEDUP_EN: each paddle hit speeds the ball up
// horizontally by one pixel per frame, capped at MAX_SPEED_X.
//
// state  | meaning
// S_IDLE | ball parked at screen centre, waiting for serve
// S_MOVE | ball in play, position updated on every frame tick
// S_MISS | ball went past the paddle, hidden for MISS_FRAMES ticks

module draw_ball
    import vga_pkg::*;
#(
    parameter int          BALL_SIZE   = 10,
    parameter int          SPEED_X     = 4,
    parameter int          SPEED_Y     = 3,
    parameter int          PADDLE_X    = 30,
    parameter int          PADDLE_W    = 15,
    parameter int          PADDLE_H    = 100,
    parameter int          MISS_FRAMES = 60,
    parameter int          MAX_SPEED_X = 12,
    parameter logic [11:0] COLOR       = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga,
    vga_if.out          vga_out,
    input  logic [10:0] paddle_y,
    input  logic        serve,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        miss
);

    // speed register is sized from the cap so both builds share one width
    localparam int SPD_W = $clog2(MAX_SPEED_X + 1);
    localparam int CNT_W = $clog2(MISS_FRAMES + 1);

    localparam logic [10:0] CENTRE_X = 11'(HOR_PIXELS / 2 - BALL_SIZE / 2);
    localparam logic [10:0] CENTRE_Y = 11'(VER_PIXELS / 2 - BALL_SIZE / 2);

    localparam logic signed [11:0] S_BS   = 12'(BALL_SIZE);
    localparam logic signed [11:0] S_SY   = 12'(SPEED_Y);
    localparam logic signed [11:0] S_HOR  = 12'(HOR_PIXELS);
    localparam logic signed [11:0] S_VER  = 12'(VER_PIXELS);
    localparam logic signed [11:0] S_FACE = 12'(PADDLE_X + PADDLE_W);
    localparam logic signed [11:0] S_PH   = 12'(PADDLE_H);
    localparam logic signed [11:0] S_ONE  = 12'sd1;
    localparam logic signed [11:0] S_ZERO = 12'sd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [10:0]        r_ball_x, w_ball_x_nxt;
    logic [10:0]        r_ball_y, w_ball_y_nxt;
    logic               r_dir_left, w_dir_left_nxt;
    logic               r_dir_down, w_dir_down_nxt;
    logic               r_miss, w_miss_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_prev_vblnk;
    logic [SPD_W-1:0]   w_speed_x;

    logic               w_tick;
    logic               w_draw;
    logic               w_hit;
    logic signed [11:0] w_bx, w_by, w_py, w_spd, w_nx;

`ifdef BALL_SPEEDUP_EN
    logic [SPD_W-1:0]   r_speed_x, w_speed_nxt;
    assign w_speed_x = r_speed_x;
`else
    assign w_speed_x = SPD_W'(SPEED_X);
`endif

    assign w_tick = vga.vblnk & ~r_prev_vblnk;
    assign w_bx   = $signed({1'b0, r_ball_x});
    assign w_by   = $signed({1'b0, r_ball_y});
    assign w_py   = $signed({1'b0, paddle_y});
    assign w_spd  = $signed({{(12 - SPD_W){1'b0}}, w_speed_x});
    assign w_nx   = w_bx - w_spd;

    // paddle face catches the ball only if it crosses the face this frame
    assign w_hit = (w_nx <= S_FACE) && (w_bx > S_FACE) &&
                   (w_by + S_BS - S_ONE >= w_py) && (w_by <= w_py + S_PH);

    assign w_draw = (r_state != S_MISS) &&
                    (vga.hcount >= r_ball_x) && (vga.hcount <= r_ball_x + 11'(BALL_SIZE - 1)) &&
                    (vga.vcount >= r_ball_y) && (vga.vcount <= r_ball_y + 11'(BALL_SIZE - 1));

    assign ball_x = r_ball_x;
    assign ball_y = r_ball_y;
    assign miss   = r_miss;

    // FSM state and ball motion registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ball_x     <= CENTRE_X;
            r_ball_y     <= CENTRE_Y;
            r_dir_left   <= 1'b1;
            r_dir_down   <= 1'b1;
            r_miss       <= 1'b0;
            r_cnt        <= '0;
            r_prev_vblnk <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            r_speed_x    <= SPD_W'(SPEED_X);
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ball_x     <= w_ball_x_nxt;
            r_ball_y     <= w_ball_y_nxt;
            r_dir_left   <= w_dir_left_nxt;
            r_dir_down   <= w_dir_down_nxt;
            r_miss       <= w_miss_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_vblnk <= vga.vblnk;
`ifdef BALL_SPEEDUP_EN
            r_speed_x    <= w_speed_nxt;
`endif
        end
    end

    // next state and per-tick move rules
    always_comb begin
        w_state_nxt    = r_state;
        w_ball_x_nxt   = r_ball_x;
        w_ball_y_nxt   = r_ball_y;
        w_dir_left_nxt = r_dir_left;
        w_dir_down_nxt = r_dir_down;
        w_miss_nxt     = 1'b0;
        w_cnt_nxt      = r_cnt;
`ifdef BALL_SPEEDUP_EN
        w_speed_nxt    = r_speed_x;
`endif
        case (r_state)
            S_IDLE: begin
                if (serve) w_state_nxt = S_MOVE;
            end
            S_MOVE: begin
                if (w_tick) begin
                    if (!r_dir_down) begin
                        if (w_by <= S_SY) begin
                            w_ball_y_nxt   = '0;
                            w_dir_down_nxt = 1'b1;
                        end else begin
                            w_ball_y_nxt = 11'(w_by - S_SY);
                        end
                    end else if (w_by + S_BS + S_SY >= S_VER) begin
                        w_ball_y_nxt   = 11'(S_VER - S_BS);
                        w_dir_down_nxt = 1'b0;
                    end else begin
                        w_ball_y_nxt = 11'(w_by + S_SY);
                    end

                    if (!r_dir_left) begin
                        if (w_bx + S_BS + w_spd >= S_HOR) begin
                            w_ball_x_nxt   = 11'(S_HOR - S_BS);
                            w_dir_left_nxt = 1'b1;
                        end else begin
                            w_ball_x_nxt = 11'(w_bx + w_spd);
                        end
                    end else if (w_hit) begin
                        w_ball_x_nxt   = 11'(S_FACE + S_ONE);
                        w_dir_left_nxt = 1'b0;
`ifdef BALL_SPEEDUP_EN
                        if (r_speed_x < SPD_W'(MAX_SPEED_X)) w_speed_nxt = r_speed_x + 1'b1;
`endif
                    end else if (w_nx <= S_ZERO) begin
                        w_ball_x_nxt = '0;
                        w_miss_nxt   = 1'b1;
                        w_state_nxt  = S_MISS;
                        w_cnt_nxt    = CNT_W'(MISS_FRAMES - 1);
                    end else begin
                        w_ball_x_nxt = 11'(w_nx);
                    end
                end
            end
            S_MISS: begin
                if (w_tick) begin
                    if (r_cnt == '0) begin
                        w_state_nxt    = S_IDLE;
                        w_ball_x_nxt   = CENTRE_X;
                        w_ball_y_nxt   = CENTRE_Y;
                        w_dir_left_nxt = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        w_speed_nxt    = SPD_W'(SPEED_X);
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // pixel path: one-cycle copy of the stream with the ball overlaid
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= vga.hcount;
            vga_out.vcount <= vga.vcount;
            vga_out.hsync  <= vga.hsync;
            vga_out.vsync  <= vga.vsync;
            vga_out.hblnk  <= vga.hblnk;
            vga_out.vblnk  <= vga.vblnk;
            vga_out.rgb    <= w_draw ? COLOR : vga.rgb;
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Randomised bench for draw_ball: short synthetic frames, random pixel
// coordinates clustered around the ball, random paddle placement, and a
// frame-level reference model of the game rules.

module tb_draw_ball;

    localparam int HOR   = 800;
    localparam int VER   = 600;
    localparam int BS    = 10;
    localparam int SX    = 4;
    localparam int SY    = 3;
    localparam int FACE  = 45;
    localparam int PH    = 100;
    localparam int MF    = 60;
    localparam int MAXSX = 12;
    localparam int CX    = HOR / 2 - BS / 2;
    localparam int CY    = VER / 2 - BS / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        serve;
    logic [10:0] paddle_y;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        miss;

    vga_if vga_in ();
    vga_if vga_o ();

    always #5 clk = ~clk;

    draw_ball dut (
        .clk      (clk),
        .rst      (rst),
        .vga      (vga_in),
        .vga_out  (vga_o),
        .paddle_y (paddle_y),
        .serve    (serve),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .miss     (miss)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // reference model: mode 0 waiting, 1 in play, 2 hidden after a miss
    int m_mode, m_bx, m_by, m_left, m_down, m_spd, m_ticks, m_prev;
    int n_miss_seen;
    logic [10:0] e_bx, e_by;
    logic        e_miss;
    logic [11:0] e_rgb;
    logic [25:0] e_tim;
    bit          e_valid;

    task automatic model_reset();
        m_mode  = 0;
        m_bx    = CX;
        m_by    = CY;
        m_left  = 1;
        m_down  = 1;
        m_spd   = SX;
        m_ticks = 0;
        m_prev  = 0;
    endtask

    task automatic model_step();
        int  hc, vc, py, nbx, nby, nx;
        bit  tick, shown;
        if (rst) begin
            model_reset();
            e_rgb  = '0;
            e_tim  = '0;
            e_miss = 1'b0;
            e_bx   = 11'(m_bx);
            e_by   = 11'(m_by);
            return;
        end
        tick   = (vga_in.vblnk == 1'b1) && (m_prev == 0);
        m_prev = int'(vga_in.vblnk);
        hc = int'(vga_in.hcount);
        vc = int'(vga_in.vcount);
        py = int'(paddle_y);
        shown = (m_mode != 2) && hc >= m_bx && hc < m_bx + BS && vc >= m_by && vc < m_by + BS;
        e_rgb  = shown ? 12'hfff : vga_in.rgb;
        e_tim  = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk};
        e_miss = 1'b0;
        if (m_mode == 0) begin
            if (serve) m_mode = 1;
        end else if (m_mode == 1 && tick) begin
            if (m_down == 0) begin
                if (m_by <= SY) begin nby = 0; m_down = 1; end
                else nby = m_by - SY;
            end else begin
                if (m_by + BS + SY >= VER) begin nby = VER - BS; m_down = 0; end
                else nby = m_by + SY;
            end
            if (m_left == 0) begin
                if (m_bx + BS + m_spd >= HOR) begin nbx = HOR - BS; m_left = 1; end
                else nbx = m_bx + m_spd;
            end else begin
                nx = m_bx - m_spd;
                if (nx <= FACE && m_bx > FACE && m_by + BS - 1 >= py && m_by <= py + PH) begin
                    nbx = FACE + 1;
                    m_left = 0;
`ifdef BALL_SPEEDUP_EN
                    if (m_spd < MAXSX) m_spd++;
`endif
                end else if (nx <= 0) begin
                    nbx = 0;
                    e_miss = 1'b1;
                    m_mode = 2;
                    m_ticks = 0;
                    n_miss_seen++;
                end else begin
                    nbx = nx;
                end
            end
            m_bx = nbx;
            m_by = nby;
        end else if (m_mode == 2 && tick) begin
            m_ticks++;
            if (m_ticks == MF) begin
                m_mode = 0;
                m_bx   = CX;
                m_by   = CY;
                m_left = 1;
                m_spd  = SX;
            end
        end
        e_bx = 11'(m_bx);
        e_by = 11'(m_by);
    endtask

    task automatic compare_outputs();
        chk("ball_x", 32'(ball_x), 32'(e_bx));
        chk("ball_y", 32'(ball_y), 32'(e_by));
        chk("miss", 32'(miss), 32'(e_miss));
        chk("rgb", 32'(vga_o.rgb), 32'(e_rgb));
        chk("timing", 32'({vga_o.hcount, vga_o.vcount, vga_o.hsync, vga_o.vsync,
                           vga_o.hblnk, vga_o.vblnk}), 32'(e_tim));
    endtask

    int  rst_hold  = 0;
    bit  did_mid_rst = 0;
    logic [10:0] frame_py;

    task automatic cycle(input bit force_rst, input bit vb);
        int h, v;
        @(negedge clk);
        if (e_valid) compare_outputs();
        if (!did_mid_rst && m_mode == 2 && m_ticks == 30) begin
            did_mid_rst = 1;
            rst_hold = 2;
        end
        if (force_rst) rst = 1'b1;
        else if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
        else rst = ($urandom_range(0, 9999) == 0);
        serve = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
        paddle_y = frame_py;
        if ($urandom_range(0, 1) == 0) begin
            h = m_bx + int'($urandom_range(0, 15)) - 3;
            v = m_by + int'($urandom_range(0, 15)) - 3;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
        end else begin
            h = int'($urandom_range(0, 2047));
            v = int'($urandom_range(0, 2047));
        end
        vga_in.hcount = 11'(h);
        vga_in.vcount = 11'(v);
        vga_in.hsync  = 1'($urandom);
        vga_in.vsync  = 1'($urandom);
        vga_in.hblnk  = 1'($urandom);
        vga_in.vblnk  = vb;
        vga_in.rgb    = 12'($urandom);
        model_step();
        e_valid = 1;
    endtask

    initial begin
        int p;
        rst = 1'b1;
        serve = 1'b0;
        paddle_y = '0;
        frame_py = '0;
        vga_in.hcount = '0;
        vga_in.vcount = '0;
        vga_in.hsync = 1'b0;
        vga_in.vsync = 1'b0;
        vga_in.hblnk = 1'b0;
        vga_in.vblnk = 1'b0;
        vga_in.rgb = '0;
        e_valid = 0;
        n_miss_seen = 0;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0);
        for (int f = 0; f < 2500; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                p = m_by - int'($urandom_range(0, 95));
                if (p < 0) p = 0;
            end else begin
                p = int'($urandom_range(0, 599));
            end
            frame_py = 11'(p);
            for (int i = 0; i < int'($urandom_range(8, 20)); i++) cycle(1'b0, 1'b0);
            for (int i = 0; i < int'($urandom_range(2, 5)); i++) cycle(1'b0, 1'b1);
        end
        @(negedge clk);
        compare_outputs();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/draw_ball.md
Name: draw_ball

Overview:
- Ball stage directly downstream of the left-paddle draw stage.
- Takes that stage's VGA stream (vga_if) and its paddle y_position. Overlays the ball on the stream and moves the ball once per frame.
- Bounces the ball off the top, bottom and right walls and off the paddle. Flags a miss when the ball passes the paddle.
- Its output feeds the next draw or score stage.

Parameters:
- BALL_SIZE, 10, ball edge length in pixels.
- SPEED_X, 4, horizontal step per frame in pixels.
- SPEED_Y, 3, vertical step per frame in pixels.
- PADDLE_X, 30, paddle left edge column.
- PADDLE_W, 15, paddle width; the paddle face is at column PADDLE_X+PADDLE_W.
- PADDLE_H, 100, paddle height.
- MISS_FRAMES, 60, frames the ball stays hidden after a miss.
- MAX_SPEED_X, 12, horizontal speed cap; used only with BALL_SPEEDUP_EN.
- COLOR, 12'hfff, ball RGB.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- vga  in  vga_if.in  upstream timing and rgb (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
- vga_out  out  vga_if.out  registered timing with rgb overlaid.
- paddle_y  in  11  paddle top row from the paddle stage.
- serve  in  1  level; launches the ball from IDLE.
- ball_x  out  11  ball left column, registered.
- ball_y  out  11  ball top row, registered.
- miss  out  1  one-cycle pulse when the ball exits past the paddle.

Behaviour:
- Clock and reset: a single clock, clk. rst is synchronous and active-high.
- Reset values:
  - all vga_out fields 0;
  - miss 0;
  - state IDLE;
  - ball_x = HOR_PIXELS/2 - BALL_SIZE/2, ball_y = VER_PIXELS/2 - BALL_SIZE/2 (from vga_pkg);
  - direction x = left, direction y = down;
  - speed_x = SPEED_X;
  - prev_vblnk 0.
- Pixel path: 1-cycle latency. All timing fields are copied from vga to vga_out on each clk.
  - vga_out.rgb = COLOR when all of the following hold:
    - state != MISS;
    - ball_x <= vga.hcount <= ball_x+BALL_SIZE-1;
    - ball_y <= vga.vcount <= ball_y+BALL_SIZE-1.
  - Otherwise vga_out.rgb = vga.rgb.
  - The compare uses the current-cycle vga inputs, not vga_out.
- Frame tick: tick = vga.vblnk & ~prev_vblnk, where prev_vblnk is registered. The tick is one cycle per frame. The ball changes position only on a tick.
- FSM:
  - IDLE: the ball is drawn at the centre.
    - serve=1 -> MOVE on the next cycle. A tick in the same cycle causes no movement.
  - MOVE: on each tick apply the move rules below. serve is ignored.
  - MISS: the ball is hidden and a frame counter counts ticks.
    - After MISS_FRAMES ticks -> IDLE, with the position recentred, direction x = left and speed_x = SPEED_X.
- Move rules (evaluated on a tick in MOVE). Arithmetic uses 12-bit signed intermediates; results are written back to 11 bits.
  - Vertical:
    - Moving up with ball_y <= SPEED_Y: ball_y = 0, direction y = down.
    - Moving down with ball_y+BALL_SIZE+SPEED_Y >= VER_PIXELS: ball_y = VER_PIXELS-BALL_SIZE, direction y = up.
    - Otherwise ball_y ± SPEED_Y.
  - Horizontal, moving right: if ball_x+BALL_SIZE+speed_x >= HOR_PIXELS, then ball_x = HOR_PIXELS-BALL_SIZE and direction x = left.
  - Horizontal, moving left, where next = ball_x - speed_x (signed). The paddle check is evaluated first.
    - Paddle hit: next <= PADDLE_X+PADDLE_W, ball_x > PADDLE_X+PADDLE_W, ball_y+BALL_SIZE-1 >= paddle_y and ball_y <= paddle_y+PADDLE_H.
      -> ball_x = PADDLE_X+PADDLE_W+1, direction x = right.
    - Miss: otherwise, if next <= 0 -> ball_x = 0, miss=1 for one cycle, state MISS.
    - Otherwise ball_x = next.
  - Horizontal and vertical updates happen in the same tick and are independent. A corner hit reflects both axes.
- paddle_y is sampled at the tick.
- rst at any time, including mid-MISS or mid-move, restores the reset values on the next edge.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined: each paddle hit sets speed_x = min(speed_x+1, MAX_SPEED_X). speed_x returns to SPEED_X on reset and on MISS->IDLE.
- Undefined: speed_x is the constant SPEED_X; the MAX_SPEED_X parameter is unused.

Test Plan:
- Reset then serve held 1 cycle -> one cycle after serve, state MOVE. ball_x and ball_y stay at centre until the first vblnk rising edge. On that tick ball_x decreases by 4 and ball_y increases by 3.
- Set ball_y=2, direction up; apply a tick -> ball_y=0, direction down. Next tick -> ball_y=3.
- Set ball_x=48, direction left, paddle_y=100, ball_y=150; apply a tick -> ball_x=46, direction right. A further tick gives ball_x=50. With BALL_SPEEDUP_EN defined, speed_x=5, so that tick gives ball_x=51.
- Set ball_x=48, paddle_y=300, ball_y=150, moving left; run ticks -> ball passes the paddle. miss pulses exactly 1 cycle when ball_x reaches 0. The ball is not drawn for 60 ticks, then it is in IDLE at the centre.
- Pixel overlay: place the ball at (200,200) and scan upstream rgb=12'h00f -> vga_out.rgb=12'hfff exactly for hcount and vcount in 200..209, one cycle after the input. Elsewhere vga_out.rgb=12'h00f. Timing fields are delayed by 1 cycle.
- Assert rst mid-MISS at frame 30 -> next cycle: IDLE, centre position, miss=0, vga_out all zero while rst is held.
